regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back arbiter that shares the integer register file's single write port between two requesters. Requester 0 is the ALU/execute result path; requester 1 is the load/memory return path. Each requester uses a valid/ready handshake. Granted writes pass through a one-entry registered output stage that drives the register file's reg_write/write_addr/write_data inputs. Writes to x0 are absorbed without using the port.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register index width (x0..x31)
CNT_WIDTH, 16, width of saturating contention counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a write pending
req0_addr  input  ADDR_WIDTH  requester 0 destination register
req0_data  input  DATA_WIDTH  requester 0 write value
req0_ready  output  1  requester 0 write accepted this cycle (combinational)
req1_valid  input  1  requester 1 has a write pending
req1_addr  input  ADDR_WIDTH  requester 1 destination register
req1_data  input  DATA_WIDTH  requester 1 write value
req1_ready  output  1  requester 1 write accepted this cycle (combinational)
reg_write  output  1  register file write enable (registered)
write_addr  output  ADDR_WIDTH  register file write index (registered)
write_data  output  DATA_WIDTH  register file write value (registered)
rr_ptr  output  1  requester holding priority on next contention
contention_cnt  output  CNT_WIDTH  cycles with two real requests, saturating

Behaviour:
- Clock is clk. Reset is rst_n, which is asynchronous and active-low. All state is cleared on rst_n low, independent of clk.
- Reset values: reg_write=0, write_addr=0, write_data=0, rr_ptr=0 (requester 0 has priority), contention_cnt=0. req*_ready is 0 while rst_n is low.
- Real request: valid=1 and addr!=0. A valid request with addr==0 is a null request.
- Null requests: ready=1 in the same cycle, no grant consumed, no port write. This is independent of the other requester.
- Grant, per cycle:
  - At most one real request is granted.
  - If exactly one requester has a real request, it is granted.
  - If both have real requests, requester rr_ptr is granted and the other sees ready=0.
- Ready rules: ready_i = null_i OR grant_i. A requester must hold valid, addr and data stable until ready is 1. The arbiter does not depend on this but requires it.
- Output stage, at the clock edge of a granted cycle N:
  - reg_write<=1, write_addr<=granted addr, write_data<=granted data.
  - The register file commits at edge N+1, so the total latency from acceptance to architectural update is 2 edges.
- If no grant in cycle N: reg_write<=0, and write_addr/write_data hold their previous values.
- rr_ptr update: after any real grant, rr_ptr<=~granted_index. It is unchanged in cycles without a real grant. Worst-case wait is therefore 1 cycle; no starvation.
- contention_cnt increments in every cycle where both requests are real. It saturates at all-ones and does not wrap.
- Same-address conflict (both real, same addr): no merging. Writes issue in grant order, so the last granted value wins in the register file.
- Back-to-back grants are allowed every cycle, giving full throughput of 1 write per cycle.
- Reset mid-operation: a write held in the output stage is discarded (reg_write forced 0). Requests presented during reset are not accepted.
- No combinational path from outputs to ready other than through the valid/addr inputs.

Test Plan:
1. Reset then idle: rst_n low for 3 cycles, then high with no valids. Required: reg_write=0, write_addr=0, write_data=0, rr_ptr=0, contention_cnt=0 throughout.
2. Single requester: req0 valid, addr=5, data=0xDEADBEEF for one cycle. Required: req0_ready=1 that cycle; next cycle reg_write=1, write_addr=5, write_data=0xDEADBEEF; the cycle after, reg_write=0.
3. Contention round-robin: both valid from reset, req0 addr=3/data=0x11, req1 addr=4/data=0x22, each dropping valid after its ready. Required:
   - cycle 0: req0 granted, rr_ptr becomes 1, contention_cnt=1;
   - cycle 1: req1 granted;
   - output sequence: (3,0x11) then (4,0x22).
4. x0 absorption: req0 addr=0 and req1 addr=7/data=0x55 valid together. Required: both ready=1 in the same cycle; only (7,0x55) appears on the port; contention_cnt unchanged.
5. Same-address ordering: rr_ptr=1; both real with addr=9, req0 data=0xA, req1 data=0xB. Required: output sequence (9,0xB) then (9,0xA).
6. Saturation and async reset: with CNT_WIDTH=4, hold contention 20 cycles. Required: contention_cnt stops at 15. Then drop rst_n mid-cycle while reg_write=1. Required: reg_write=0 and contention_cnt=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the two write-back requester handshakes and the register file
// write port shared by the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;

  // Requesters and register file side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  reg_write, write_addr, write_data
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output reg_write, write_addr, write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// and load return paths, with x0 writes absorbed and a registered output stage.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus,
  output logic                 rr_ptr,
  output logic [CNT_WIDTH-1:0] contention_cnt
);

  logic real0, real1;
  logic null0, null1;
  logic grant0, grant1;

  // A valid write to x0 is acknowledged immediately and never reaches the port.
  always_comb begin
    real0  = bus.req0_valid && (bus.req0_addr != '0);
    real1  = bus.req1_valid && (bus.req1_addr != '0);
    null0  = bus.req0_valid && (bus.req0_addr == '0);
    null1  = bus.req1_valid && (bus.req1_addr == '0);
    grant0 = rst_n && real0 && (!real1 || !rr_ptr);
    grant1 = rst_n && real1 && (!real0 ||  rr_ptr);
    bus.req0_ready = rst_n && (null0 || grant0);
    bus.req1_ready = rst_n && (null1 || grant1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.reg_write  <= 1'b0;
      bus.write_addr <= '0;
      bus.write_data <= '0;
    end else begin
      bus.reg_write <= grant0 || grant1;
      if (grant0) begin
        bus.write_addr <= bus.req0_addr;
        bus.write_data <= bus.req0_data;
      end else if (grant1) begin
        bus.write_addr <= bus.req1_addr;
        bus.write_data <= bus.req1_data;
      end
    end
  end

  // Priority passes to the loser after every real grant, bounding any wait to one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= 1'b0;
      contention_cnt <= '0;
    end else begin
      if (grant0) begin
        rr_ptr <= 1'b1;
      end else if (grant1) begin
        rr_ptr <= 1'b0;
      end
      if (real0 && real1 && (contention_cnt != '1)) begin
        contention_cnt <= contention_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected port writes are queued when a
// grant is predicted and popped when the output stage presents them.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk;
  logic          rst_n;
  logic          rr_ptr;
  logic [CW-1:0] contention_cnt;

  regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .rr_ptr         (rr_ptr),
    .contention_cnt (contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  wr_t           sb_q[$];
  logic          m_rr;
  int            m_cnt;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_rr     = 1'b0;
    m_cnt    = 0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  // Output stage check one step after the edge; hold behaviour when nothing was granted.
  task automatic check_output();
    wr_t e;
    chk("rr_ptr", 64'(rr_ptr), 64'(m_rr));
    chk("contention_cnt", 64'(contention_cnt), 64'(m_cnt));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      exp_addr = e.a;
      exp_data = e.d;
      chk("reg_write", 64'(bus.reg_write), 64'(1));
    end else begin
      chk("reg_write", 64'(bus.reg_write), 64'(0));
    end
    chk("write_addr", 64'(bus.write_addr), 64'(exp_addr));
    chk("write_data", 64'(bus.write_data), 64'(exp_data));
  endtask

  task automatic apply_stimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic r0, r1, g0, g1;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    #1;
    r0 = v0 && (a0 != 0);
    r1 = v1 && (a1 != 0);
    g0 = r0 && (!r1 || !m_rr);
    g1 = r1 && (!r0 ||  m_rr);
    chk("req0_ready", 64'(bus.req0_ready), 64'((v0 && a0 == 0) || g0));
    chk("req1_ready", 64'(bus.req1_ready), 64'((v1 && a1 == 0) || g1));
    if (g0) sb_q.push_back('{a0, d0});
    else if (g1) sb_q.push_back('{a1, d1});
    if (r0 && r1 && m_cnt != 15) m_cnt++;
    if (g0) m_rr = 1'b1;
    else if (g1) m_rr = 1'b0;
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic idle();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req0_ready", 64'(bus.req0_ready), 64'(0));
    chk("rst_req1_ready", 64'(bus.req1_ready), 64'(0));
    check_output();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    rst_n = 1'b1;
    model_reset();

    $display("[TB] reset then idle");
    do_reset(1'b1, 5'd6, 32'h1, 1'b1, 5'd8, 32'h2);
    repeat (3) idle();

    $display("[TB] single requester");
    apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    chk("t2_addr", 64'(bus.write_addr), 64'(5));
    chk("t2_data", 64'(bus.write_data), 64'(32'hDEADBEEF));
    idle();
    idle();

    $display("[TB] contention round-robin");
    do_reset(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    apply_stimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    chk("t3_rr_after_c0", 64'(rr_ptr), 64'(1));
    chk("t3_cnt_after_c0", 64'(contention_cnt), 64'(1));
    chk("t3_first_addr", 64'(bus.write_addr), 64'(3));
    apply_stimulus(1'b0, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    chk("t3_second_data", 64'(bus.write_data), 64'(32'h22));
    idle();

    $display("[TB] x0 absorption");
    apply_stimulus(1'b1, 5'd0, 32'h99, 1'b1, 5'd7, 32'h55);
    chk("t4_cnt_unchanged", 64'(contention_cnt), 64'(1));
    chk("t4_addr", 64'(bus.write_addr), 64'(7));
    apply_stimulus(1'b1, 5'd0, 32'h98, 1'b0, '0, '0);

    $display("[TB] same-address ordering");
    apply_stimulus(1'b1, 5'd2, 32'h33, 1'b0, '0, '0);
    chk("t5_rr_set", 64'(rr_ptr), 64'(1));
    apply_stimulus(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
    chk("t5_first_data", 64'(bus.write_data), 64'(32'hB));
    apply_stimulus(1'b1, 5'd9, 32'hA, 1'b0, '0, '0);
    chk("t5_second_data", 64'(bus.write_data), 64'(32'hA));
    idle();

    $display("[TB] saturation and async reset");
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 5'd10, DW'(i), 1'b1, 5'd11, DW'(i + 100));
    end
    chk("t6_cnt_saturated", 64'(contention_cnt), 64'(15));
    chk("t6_reg_write_before", 64'(bus.reg_write), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_reg_write", 64'(bus.reg_write), 64'(0));
    chk("t6_async_cnt", 64'(contention_cnt), 64'(0));
    chk("t6_async_rr", 64'(rr_ptr), 64'(0));
    chk("t6_async_req0_ready", 64'(bus.req0_ready), 64'(0));
    chk("t6_async_req1_ready", 64'(bus.req1_ready), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    apply_stimulus(1'b1, 5'd12, 32'hCAFE, 1'b0, '0, '0);
    idle();

    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
